// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
//   Boot/bench program loader: takes symbolic LEGv8 instruction requests over
//   a valid/ready handshake, assembles 32-bit D, CB and R format machine
//   words and writes them to instruction memory at word-aligned,
//   auto-incrementing byte addresses.
//
//   Optional build macro: ENCODER_RANGE_CHECK_EN
//     defined   : a D-format immediate outside -256..255 makes the request illegal
//     undefined : a D-format immediate is truncated to imm[8:0]

module legv8_instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [18:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              full,
    output logic              err,
    output logic [ADDR_W-2:0] count
);

    // Request operation classes
    typedef enum logic [2:0] {
        OP_LDUR    = 3'b000,
        OP_STUR    = 3'b001,
        OP_CBZ     = 3'b010,
        OP_ADD     = 3'b011,
        OP_SUB     = 3'b100,
        OP_AND     = 3'b101,
        OP_ORR     = 3'b110,
        OP_ILLEGAL = 3'b111
    } req_op_t;

    // Loader control states
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Major opcode fields
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;

    // Highest word-aligned byte address; writing here exhausts the memory
    localparam logic [ADDR_W-1:0] LAST_PTR  = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-2:0] COUNT_ONE = (ADDR_W-1)'(1);

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              err_q,       err_d;
    logic [ADDR_W-2:0] count_q,     count_d;

    req_op_t     op;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        is_dfmt;
    logic        accept;

    assign op = req_op_t'(req_op);

    // Handshake: base_load steals the cycle from any simultaneous request
    always_comb begin
        req_ready = (state_q == ST_RUN) && !base_load;
        accept    = req_valid && req_ready;
    end

    // Assemble the machine word; fields a format does not use are never read
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        is_dfmt   = 1'b0;
        case (op)
            OP_LDUR: begin
                enc_word = {OPC_LDUR, req_imm[8:0], 2'b00, req_rn, req_rd};
                is_dfmt  = 1'b1;
            end
            OP_STUR: begin
                enc_word = {OPC_STUR, req_imm[8:0], 2'b00, req_rn, req_rd};
                is_dfmt  = 1'b1;
            end
            OP_CBZ:  enc_word  = {OPC_CBZ, req_imm, req_rd};
            OP_ADD:  enc_word  = {OPC_ADD, req_rm, 6'b000000, req_rn, req_rd};
            OP_SUB:  enc_word  = {OPC_SUB, req_rm, 6'b000000, req_rn, req_rd};
            OP_AND:  enc_word  = {OPC_AND, req_rm, 6'b000000, req_rn, req_rd};
            OP_ORR:  enc_word  = {OPC_ORR, req_rm, 6'b000000, req_rn, req_rd};
            default: enc_legal = 1'b0;
        endcase
`ifdef ENCODER_RANGE_CHECK_EN
        // DT_address is 9-bit signed: imm[18:8] must all match the sign bit
        if (is_dfmt && !((&req_imm[18:8]) || !(|req_imm[18:8]))) begin
            enc_legal = 1'b0;
        end
`endif
    end

    // Next-state: pointer, strobe, sticky error, word count and FSM
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        count_d     = count_q;

        if (base_load) begin
            // A strobe already registered from the previous accept still
            // goes out this cycle; only the pointer bookkeeping restarts.
            ptr_d   = {base_addr[ADDR_W-1:2], 2'b00};
            state_d = ST_RUN;
            err_d   = 1'b0;
            count_d = '0;
        end else if (accept) begin
            if (enc_legal) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = ptr_q;
                mem_wdata_d = enc_word;
                ptr_d       = ptr_q + PTR_STEP;
                if (count_q != '1) begin
                    count_d = count_q + COUNT_ONE;
                end
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_FULL;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            ptr_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign full      = (state_q == ST_FULL);
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed-vector bench for legv8_instr_encoder: default-size instance for
// encodings/handshake and a 4-bit-address instance for the full condition.

module tb_legv8_instr_encoder;

    logic        clock;
    logic        reset_n;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rn;
    logic [4:0]  req_rm;
    logic [18:0] req_imm;

    // Default instance (ADDR_W = 8)
    logic        base_load;
    logic [7:0]  base_addr;
    logic        req_valid;
    logic        req_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        full;
    logic        err;
    logic [6:0]  count;

    // Small instance (ADDR_W = 4)
    logic        s_base_load;
    logic [3:0]  s_base_addr;
    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_mem_we;
    logic [3:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic        s_full;
    logic        s_err;
    logic [2:0]  s_count;

    int unsigned n_vec;
    int unsigned n_miss;

    legv8_instr_encoder #(.ADDR_W(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .base_load(base_load),
        .base_addr(base_addr),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_rd   (req_rd),
        .req_rn   (req_rn),
        .req_rm   (req_rm),
        .req_imm  (req_imm),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .full     (full),
        .err      (err),
        .count    (count)
    );

    legv8_instr_encoder #(.ADDR_W(4)) dut_small (
        .clock    (clock),
        .reset_n  (reset_n),
        .base_load(s_base_load),
        .base_addr(s_base_addr),
        .req_valid(s_req_valid),
        .req_ready(s_req_ready),
        .req_op   (req_op),
        .req_rd   (req_rd),
        .req_rn   (req_rn),
        .req_rm   (req_rm),
        .req_imm  (req_imm),
        .mem_we   (s_mem_we),
        .mem_addr (s_mem_addr),
        .mem_wdata(s_mem_wdata),
        .full     (s_full),
        .err      (s_err),
        .count    (s_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [18:0] imm);
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_rn    = rn;
        req_rm    = rm;
        req_imm   = imm;
    endtask

    // Expect one write strobe from the default instance
    task automatic expect_wr(input string tag, input logic [7:0] addr, input logic [31:0] word,
                             input logic [6:0] cnt);
        check({tag, ".we"},    {31'd0, mem_we}, 32'd1);
        check({tag, ".addr"},  {24'd0, mem_addr}, {24'd0, addr});
        check({tag, ".wdata"}, mem_wdata, word);
        check({tag, ".count"}, {25'd0, count}, {25'd0, cnt});
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        reset_n     = 1'b0;
        base_load   = 1'b0;
        base_addr   = '0;
        req_valid   = 1'b0;
        s_base_load = 1'b0;
        s_base_addr = '0;
        s_req_valid = 1'b0;
        req_op      = '0;
        req_rd      = '0;
        req_rn      = '0;
        req_rm      = '0;
        req_imm     = '0;
        step();
        step();

        // Reset state
        check("rst.we",    {31'd0, mem_we}, 32'd0);
        check("rst.addr",  {24'd0, mem_addr}, 32'd0);
        check("rst.wdata", mem_wdata, 32'd0);
        check("rst.full",  {31'd0, full}, 32'd0);
        check("rst.err",   {31'd0, err}, 32'd0);
        check("rst.count", {25'd0, count}, 32'd0);
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        reset_n = 1'b1;
        step();

        // base_load with unaligned address -> pointer 0x10; blocks ready
        base_load = 1'b1;
        base_addr = 8'h13;
        req_valid = 1'b1;
        #1 check("bl.ready", {31'd0, req_ready}, 32'd0);
        step();
        check("bl.we", {31'd0, mem_we}, 32'd0);
        base_load = 1'b0;

        // LDUR rd=1 rn=2 imm=8; rm set to prove it does not leak
        drive(3'b000, 5'd1, 5'd2, 5'd31, 19'd8);
        step();
        expect_wr("ldur", 8'h10, 32'hF8408041, 7'd1);
        // Back-to-back ADD then CBZ (rn/rm of CBZ must not leak)
        drive(3'b011, 5'd3, 5'd1, 5'd2, 19'h7FFFF);
        step();
        expect_wr("add", 8'h14, 32'h8B020023, 7'd2);
        drive(3'b010, 5'd5, 5'd31, 5'd31, 19'd3);
        step();
        expect_wr("cbz", 8'h18, 32'hB4000065, 7'd3);
        req_valid = 1'b0;
        step();
        check("idle.we",    {31'd0, mem_we}, 32'd0);
        check("idle.wdata", mem_wdata, 32'hB4000065);

        // STUR with imm = -1
        drive(3'b001, 5'd4, 5'd6, 5'd0, 19'h7FFFF);
        step();
        expect_wr("stur", 8'h1C, 32'hF81FF0C4, 7'd4);

        // Illegal op consumed, no write, err sticky
        drive(3'b111, 5'd9, 5'd9, 5'd9, 19'd9);
        step();
        check("ill.we",    {31'd0, mem_we}, 32'd0);
        check("ill.err",   {31'd0, err}, 32'd1);
        check("ill.count", {25'd0, count}, 32'd4);
        drive(3'b100, 5'd31, 5'd31, 5'd31, 19'd0);
        step();
        expect_wr("sub", 8'h20, 32'hCB1F03FF, 7'd5);
        check("sub.err", {31'd0, err}, 32'd1);
        drive(3'b101, 5'd7, 5'd8, 5'd9, 19'h12345);
        step();
        expect_wr("and", 8'h24, 32'h8A090107, 7'd6);
        drive(3'b110, 5'd2, 5'd3, 5'd4, 19'd0);
        step();
        expect_wr("orr", 8'h28, 32'hAA040062, 7'd7);
        drive(3'b010, 5'd0, 5'd31, 5'd31, 19'h7FFFF);
        step();
        expect_wr("cbzneg", 8'h2C, 32'hB4FFFFE0, 7'd8);

        // base_load clears err/count
        req_valid = 1'b0;
        base_load = 1'b1;
        base_addr = 8'h40;
        step();
        base_load = 1'b0;
        check("bl2.err",   {31'd0, err}, 32'd0);
        check("bl2.count", {25'd0, count}, 32'd0);

        // D-format immediate out of 9-bit signed range
        drive(3'b000, 5'd0, 5'd0, 5'd31, 19'h00100);
        step();
`ifdef ENCODER_RANGE_CHECK_EN
        check("rng.we",    {31'd0, mem_we}, 32'd0);
        check("rng.err",   {31'd0, err}, 32'd1);
        check("rng.count", {25'd0, count}, 32'd0);
`else
        expect_wr("rng", 8'h40, 32'hF8500000, 7'd1);
        check("rng.err", {31'd0, err}, 32'd0);
`endif

        // Async reset mid-stream
        drive(3'b011, 5'd1, 5'd1, 5'd1, 19'd0);
        step();
        check("mid.we", {31'd0, mem_we}, 32'd1);
        req_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst.we",    {31'd0, mem_we}, 32'd0);
        check("arst.addr",  {24'd0, mem_addr}, 32'd0);
        check("arst.wdata", mem_wdata, 32'd0);
        check("arst.count", {25'd0, count}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Small instance: base 0x9 -> 0x8, fill the last two words
        s_base_load = 1'b1;
        s_base_addr = 4'h9;
        step();
        s_base_load = 1'b0;
        s_req_valid = 1'b1;
        drive(3'b011, 5'd3, 5'd1, 5'd2, 19'd0);
        req_valid = 1'b0;
        step();
        check("s1.we",   {31'd0, s_mem_we}, 32'd1);
        check("s1.addr", {28'd0, s_mem_addr}, 32'h8);
        check("s1.full", {31'd0, s_full}, 32'd0);
        step();
        check("s2.we",    {31'd0, s_mem_we}, 32'd1);
        check("s2.addr",  {28'd0, s_mem_addr}, 32'hC);
        check("s2.full",  {31'd0, s_full}, 32'd1);
        check("s2.ready", {31'd0, s_req_ready}, 32'd0);
        check("s2.count", {29'd0, s_count}, 32'd2);
        step();
        check("s3.we", {31'd0, s_mem_we}, 32'd0);
        // Simultaneous base_load + request: request not accepted
        s_base_load = 1'b1;
        s_base_addr = 4'h4;
        #1 check("s4.ready", {31'd0, s_req_ready}, 32'd0);
        step();
        check("s4.we",    {31'd0, s_mem_we}, 32'd0);
        check("s4.full",  {31'd0, s_full}, 32'd0);
        check("s4.count", {29'd0, s_count}, 32'd0);
        s_base_load = 1'b0;
        step();
        check("s5.we",   {31'd0, s_mem_we}, 32'd1);
        check("s5.addr", {28'd0, s_mem_addr}, 32'h4);
        s_req_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
